// File: rtl/time_fmt_pkg.sv
// Shared types and constants for the picosecond-to-ASCII nanosecond serializer.
// Holds the FSM state encoding, ASCII codes and the integer-digit counting helper.
package time_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_PAD,
        ST_DIGITS,
        ST_SUFFIX
    } state_t;

    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_N     = 8'h6E;
    localparam logic [7:0] ASCII_S     = 8'h73;

    // Integer part lives in digits 9..3; a value below 1 ns still prints one '0'.
    function automatic logic [3:0] int_digit_count(input logic [BCD_W-1:0] bcd);
        logic [3:0] cnt;
        cnt = 4'd1;
        for (int i = 3; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) cnt = 4'(i - 2);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle.
// The first bit is consumed on the start cycle, so done rises 31 cycles later.
module bin2bcd_seq
    import time_fmt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [30:0] shift_q;
    logic [4:0]  cnt_q;
    logic        busy_q;

    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] cur,
                                                    input logic             in_bit);
        logic [BCD_W-1:0] adj;
        logic [3:0]       d;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            d = cur[i*4 +: 4];
            if (d >= 4'd5) d = d + 4'd3;
            adj[i*4 +: 4] = d;
        end
        return {adj[BCD_W-2:0], in_bit};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd     <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            bcd     <= dabble_step('0, bin[31]);
            shift_q <= bin[30:0];
            cnt_q   <= 5'd31;
            busy_q  <= 1'b1;
        end else if (cnt_q != 5'd0) begin
            bcd     <= dabble_step(bcd, shift_q[30]);
            shift_q <= {shift_q[29:0], 1'b0};
            cnt_q   <= cnt_q - 5'd1;
        end
    end

    assign done = busy_q && (cnt_q == 5'd0);

endmodule

// File: rtl/time_fmt_serializer.sv
// Converts a picosecond timestamp into a right-aligned ASCII "<int>.<frac>ns"
// string, streamed one character per cycle over a valid/ready interface.
module time_fmt_serializer
    import time_fmt_pkg::*;
#(
    parameter int FRAC_DIGITS = 2,
    parameter int MIN_WIDTH   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] t_val,
    input  logic        t_valid,
    output logic        t_ready,
    output logic [7:0]  c_data,
    output logic        c_valid,
    input  logic        c_ready,
    output logic        c_last
);

    localparam logic [3:0] LAST_IDX   = 4'(3 - FRAC_DIGITS);
    localparam int         FRAC_CHARS = (FRAC_DIGITS > 0) ? FRAC_DIGITS + 1 : 0;

    state_t           state, state_next;
    logic [BCD_W-1:0] bcd;
    logic             conv_done;
    logic             start;
    logic             xfer;
    logic [3:0]       int_len;
    int               pad_calc;
    logic [7:0]       pad_cnt;
    logic [3:0]       dig_idx;
    logic [3:0]       cur_digit;
    logic             at_dot;
    logic             suffix_s;

    assign start     = t_valid && t_ready;
    assign xfer      = c_valid && c_ready;
    assign cur_digit = bcd[{dig_idx, 2'b00} +: 4];

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (t_val),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        int_len  = int_digit_count(bcd);
        pad_calc = MIN_WIDTH - (int'(int_len) + FRAC_CHARS + 2);
        if (pad_calc < 0) pad_calc = 0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_CONV;
            ST_CONV:   if (conv_done) state_next = (pad_calc > 0) ? ST_PAD : ST_DIGITS;
            ST_PAD:    if (xfer && pad_cnt == 8'd1) state_next = ST_DIGITS;
            ST_DIGITS: if (xfer && !at_dot && dig_idx == LAST_IDX) state_next = ST_SUFFIX;
            ST_SUFFIX: if (xfer && suffix_s) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so they hold still during a stall.
    always_comb begin
        t_ready = (state == ST_IDLE);
        c_valid = (state == ST_PAD) || (state == ST_DIGITS) || (state == ST_SUFFIX);
        c_last  = (state == ST_SUFFIX) && suffix_s;
        c_data  = 8'h00;
        case (state)
            ST_PAD:    c_data = ASCII_SPACE;
            ST_DIGITS: c_data = at_dot ? ASCII_DOT : (ASCII_ZERO + {4'b0, cur_digit});
            ST_SUFFIX: c_data = suffix_s ? ASCII_S : ASCII_N;
            default:   c_data = 8'h00;
        endcase
    end

    // Lengths are latched once when CONV finishes; the stream then walks digits
    // from the most significant non-zero integer digit down to LAST_IDX.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_cnt  <= '0;
            dig_idx  <= '0;
            at_dot   <= 1'b0;
            suffix_s <= 1'b0;
        end else begin
            case (state)
                ST_CONV: if (conv_done) begin
                    pad_cnt  <= 8'(pad_calc);
                    dig_idx  <= int_len + 4'd2;
                    at_dot   <= 1'b0;
                    suffix_s <= 1'b0;
                end
                ST_PAD: if (xfer) pad_cnt <= pad_cnt - 8'd1;
                ST_DIGITS: if (xfer) begin
                    if (at_dot) begin
                        at_dot <= 1'b0;
                    end else if (dig_idx == 4'd3 && FRAC_DIGITS > 0) begin
                        at_dot  <= 1'b1;
                        dig_idx <= 4'd2;
                    end else begin
                        dig_idx <= dig_idx - 4'd1;
                    end
                end
                ST_SUFFIX: if (xfer) suffix_s <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_fmt_serializer.sv
// Randomized self-checking bench: two configurations streamed against a
// string-building reference model of the ns formatting rules.
module tb_time_fmt_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] t_val_r   [2];
    logic        t_valid_r [2];
    logic        c_ready_r [2];
    logic        t_ready_w [2];
    logic [7:0]  c_data_w  [2];
    logic        c_valid_w [2];
    logic        c_last_w  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    time_fmt_serializer #(.FRAC_DIGITS(2), .MIN_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst),
        .t_val(t_val_r[0]), .t_valid(t_valid_r[0]), .t_ready(t_ready_w[0]),
        .c_data(c_data_w[0]), .c_valid(c_valid_w[0]), .c_ready(c_ready_r[0]),
        .c_last(c_last_w[0])
    );

    time_fmt_serializer #(.FRAC_DIGITS(0), .MIN_WIDTH(0)) dut_b (
        .clk(clk), .rst(rst),
        .t_val(t_val_r[1]), .t_valid(t_valid_r[1]), .t_ready(t_ready_w[1]),
        .c_data(c_data_w[1]), .c_valid(c_valid_w[1]), .c_ready(c_ready_r[1]),
        .c_last(c_last_w[1])
    );

    task automatic check(input string tag, input string got, input string exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    function automatic string num(input longint v);
        return $sformatf("%0d", v);
    endfunction

    // Reference: ps -> ns with plain integer arithmetic and string building.
    function automatic string fmt(input logic [31:0] t, input int f, input int w);
        longint unsigned v, rem, dv;
        string s;
        v   = t;
        rem = v % 1000;
        s   = $sformatf("%0d", v / 1000);
        if (f > 0) begin
            s  = {s, "."};
            dv = 100;
            for (int i = 0; i < f; i++) begin
                s  = {s, $sformatf("%0d", (rem / dv) % 10)};
                dv = dv / 10;
            end
        end
        s = {s, "ns"};
        while (s.len() < w) s = {" ", s};
        return s;
    endfunction

    // Called on a negedge; returns on the negedge of the cycle after 's' transfers.
    task automatic run(input int d, input logic [31:0] t, input int ready_pct, input bit hold);
        string got;
        string exp;
        int    waited;
        int    cyc;
        bit    seen_valid, done, prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        got        = "";
        exp        = (d == 0) ? fmt(t, 2, 10) : fmt(t, 0, 0);
        t_val_r[d]   = t;
        t_valid_r[d] = 1'b1;
        waited = 0;
        while (!t_ready_w[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!t_ready_w[d]) begin
            check("accept_timeout", "0", "1");
            t_valid_r[d] = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) t_val_r[d] = $urandom;
        else      t_valid_r[d] = 1'b0;
        check($sformatf("busy_tready[%0d]", d), num(t_ready_w[d]), "0");
        cyc = 1; seen_valid = 0; done = 0; prev_stall = 0;
        prev_data = 8'h00; prev_last = 1'b0;
        while (!done && cyc < 600) begin
            c_ready_r[d] = ($urandom_range(0, 99) < ready_pct);
            if (prev_stall) begin
                check("stall_valid", num(c_valid_w[d]), "1");
                check("stall_data", num(c_data_w[d]), num(prev_data));
                check("stall_last", num(c_last_w[d]), num(prev_last));
            end
            if (c_valid_w[d] && !seen_valid) begin
                seen_valid = 1;
                check($sformatf("latency[%0d]", d), num(cyc), "33");
            end
            if (c_valid_w[d] && c_ready_r[d]) begin
                got = $sformatf("%s%c", got, c_data_w[d]);
                if (c_last_w[d]) done = 1;
            end
            prev_stall = c_valid_w[d] && !c_ready_r[d];
            prev_data  = c_data_w[d];
            prev_last  = c_last_w[d];
            @(negedge clk);
            cyc++;
        end
        if (!done) check("stream_timeout", "0", "1");
        else       check($sformatf("return_tready[%0d]", d), num(t_ready_w[d]), "1");
        check($sformatf("str[%0d] t=%0d", d, t), got, exp);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_tready"}, num(t_ready_w[0]), "1");
        check({tag, "_cvalid"}, num(c_valid_w[0]), "0");
        check({tag, "_clast"},  num(c_last_w[0]),  "0");
        check({tag, "_cdata"},  num(c_data_w[0]),  "0");
    endtask

    // Start 13040 on dut_a with c_ready high, then pulse rst after n cycles.
    task automatic reset_after(input int n, input string tag);
        t_val_r[0] = 32'd13040; t_valid_r[0] = 1'b1; c_ready_r[0] = 1'b1;
        @(negedge clk);
        t_valid_r[0] = 1'b0;
        repeat (n - 1) @(negedge clk);
        if (n == 37) check("pre_rst_digit", num(c_data_w[0]), num(8'h33));
        rst = 1'b1;
        @(negedge clk);
        idle_checks(tag);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_quiet"}, num(c_valid_w[0]), "0");
    endtask

    initial begin
        bit hold;
        for (int i = 0; i < 2; i++) begin
            t_val_r[i] = '0; t_valid_r[i] = 1'b0; c_ready_r[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        idle_checks("reset");
        check("reset_tready_b", num(t_ready_w[1]), "1");
        rst = 1'b0;
        @(negedge clk);

        run(0, 32'd13040, 100, 0);
        run(0, 32'd0, 100, 0);
        run(0, 32'd5529, 100, 0);
        run(0, 32'hFFFF_FFFF, 100, 0);
        run(0, 32'd13040, 50, 0);
        run(1, 32'd100000, 100, 0);
        run(1, 32'd0, 100, 0);
        run(1, 32'hFFFF_FFFF, 60, 0);

        reset_after(10, "rst_conv");
        reset_after(37, "rst_digits");
        run(0, 32'd5520, 100, 0);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 12; k++) begin
                hold = (k != 11) && ($urandom_range(0, 2) == 0);
                run(d, $urandom >> $urandom_range(0, 31), 60, hold);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/time_fmt_serializer.md
TIME_FMT_SERIALIZER -- requirements
Module: time_fmt_serializer

Interface
REQ-001 SHALL have parameter FRAC_DIGITS, default 2: decimal places shown, legal range 0..3.
REQ-002 SHALL have parameter MIN_WIDTH, default 10: minimum character count of number plus "ns" suffix, left-padded with spaces.
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port t_val  input  32: timestamp, unsigned binary, picoseconds.
REQ-006 SHALL have port t_valid  input  1: t_val valid.
REQ-007 SHALL have port t_ready  output  1: block accepts a timestamp.
REQ-008 SHALL have port c_data  output  8: ASCII output character.
REQ-009 SHALL have port c_valid  output  1: c_data valid.
REQ-010 SHALL have port c_ready  input  1: downstream accepts c_data.
REQ-011 SHALL have port c_last  output  1: marks the final character ('s') of a string.

Function
REQ-012 SHALL accept a timestamp only on a cycle where t_valid and t_ready are both 1; t_ready SHALL be 1 only in IDLE.
REQ-013 SHALL use FSM IDLE -> CONV -> PAD -> DIGITS -> SUFFIX -> IDLE; PAD is skipped when no padding is required.
REQ-014 CONV SHALL convert the 32-bit value to 10 BCD digits by shift-add-3, one bit per cycle, in exactly 32 cycles.
REQ-015 The number SHALL be ps/1000 shown in ns: integer part = BCD digits 9..3, fraction = the top FRAC_DIGITS of digits 2..0, lower digits truncated with no rounding.
REQ-016 Leading integer zeros SHALL be suppressed, with at least one integer digit ('0') always emitted.
REQ-017 When FRAC_DIGITS>0, a '.' SHALL precede the fraction digits; when FRAC_DIGITS=0, no '.' SHALL be emitted.
REQ-018 Suffix SHALL be the two characters "n","s"; c_last SHALL be 1 only with 's'.
REQ-019 Padding: if L = number chars + 2 is less than MIN_WIDTH, exactly MIN_WIDTH-L spaces (8'h20) SHALL precede the number; if L >= MIN_WIDTH, no spaces and no truncation.
REQ-020 A character SHALL transfer on a cycle where c_valid and c_ready are both 1; c_data and c_last SHALL hold stable while c_valid=1 and c_ready=0.
REQ-021 c_valid SHALL be 1 on every cycle in PAD, DIGITS and SUFFIX, giving one character per cycle when c_ready is held at 1.
REQ-022 Latency: the first character SHALL be valid 33 cycles after the acceptance cycle.
REQ-023 Return to IDLE SHALL occur the cycle after 's' transfers; t_ready SHALL be 1 on that cycle.
REQ-024 t_valid SHALL be ignored outside IDLE; a held t_valid SHALL be accepted on the first IDLE cycle.

Reset
REQ-025 When rst=1 at a clock edge, the state SHALL become IDLE, with t_ready=1, c_valid=0, c_last=0, c_data=8'h00 and the BCD/shift registers at 0.
REQ-026 Reset asserted mid-CONV or mid-stream SHALL abandon the string with no further characters and no c_last.

Structure
REQ-027 Package time_fmt_pkg SHALL hold the state enum, ASCII constants (space, '0', '.', 'n', 's') and BCD_DIGITS=10.
REQ-028 Sub-module bin2bcd_seq SHALL implement the sequential double-dabble conversion (start, done, 32-bit in, 40-bit BCD out).
REQ-029 Number length and pad count SHALL be computed once, at the transition out of CONV.

Verification
REQ-030 t_val=13040, defaults, c_ready=1 -> "   13.04ns" (10 chars), c_last on char 10, first char 33 cycles after acceptance.
REQ-031 t_val=0 -> "    0.00ns"; t_val=5529 -> "    5.52ns" (truncation, not rounding).
REQ-032 t_val=32'hFFFFFFFF -> "4294967.29ns" (12 chars, no padding, no truncation).
REQ-033 FRAC_DIGITS=0, MIN_WIDTH=0, t_val=100000 -> "100ns", no '.'.
REQ-034 c_ready toggled randomly -> c_data/c_last stable while stalled; the string is identical to the REQ-030 string.
REQ-035 rst pulsed during CONV and during DIGITS -> c_valid=0 the next cycle, t_ready=1, and a following t_val=5520 -> "    5.52ns".
